clock_display_mux: RTL

Time-multiplexed 4-digit 7-segment driver for the digital clock. It reads the BCD minute and hour digits and the seconds count produced by the clock counter, then scans the four digits onto a common-anode display. It also drives the blinking colon and the blanking of fields during time-set. It sits between the counter block and the board display pins.

---
 rtl/clock_display_pkg.sv | 53 +++++
 rtl/clock_display_mux_seg7_decode.sv | 28 ++
 rtl/clock_display_mux.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/clock_display_pkg.sv
// Shared constants and types for the 4-digit multiplexed clock display.
package clock_display_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low digit enables; bit 0 is the rightmost digit.
    localparam logic [3:0] AN_MU  = 4'b1110;
    localparam logic [3:0] AN_MT  = 4'b1101;
    localparam logic [3:0] AN_HU  = 4'b1011;
    localparam logic [3:0] AN_HT  = 4'b0111;
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Scan slot, in display order.
    typedef enum logic [1:0] {
        SLOT_MU = 2'd0,
        SLOT_MT = 2'd1,
        SLOT_HU = 2'd2,
        SLOT_HT = 2'd3
    } slot_t;

    // Per-frame copy of everything the display needs; only the colon
    // parity of the seconds count is ever shown, so only that bit is kept.
    typedef struct packed {
        logic [3:0] mu;
        logic [3:0] mt;
        logic [3:0] hu;
        logic [3:0] ht;
        logic       sec_lsb;
        logic       blink_mins;
        logic       blink_hours;
    } frame_t;

    function automatic logic [3:0] slot_anode(input slot_t s);
        case (s)
            SLOT_MU: return AN_MU;
            SLOT_MT: return AN_MT;
            SLOT_HU: return AN_HU;
            default: return AN_HT;
        endcase
    endfunction

endpackage

// File: rtl/clock_display_mux_seg7_decode.sv
// BCD digit to active-low 7-segment pattern; non-decimal values go dark.
module seg7_decode
    import clock_display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Table lookup; out-of-range codes fall through to blank.
    always_comb begin
        // NOTE: default assignment first so every path drives seg (no latch).
        seg = SEG_BLANK;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_display_mux.sv
// Time-multiplexed 4-digit common-anode driver with blinking colon,
// time-set field blinking and optional hours leading-zero suppression.
module clock_display_mux
    import clock_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125,
    parameter int SUPPRESS_LZ  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] minutes_units,
    input  logic [2:0] minutes_tens,
    input  logic [3:0] hours_units,
    input  logic [2:0] hours_tens,
    input  logic [5:0] counter_sec,
    input  logic       blink_mins,
    input  logic       blink_hours,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int FC_W  = $clog2(BLINK_FRAMES + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [FC_W-1:0]  FC_TERM  = FC_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0] pre;
    slot_t            idx;
    frame_t           snap;
    logic             bph;
    logic [FC_W-1:0]  fcnt;
    logic             running;

    logic   tick;
    logic   frame_wrap;
    logic   phase_flip;
    logic   bph_eff;
    slot_t  next_slot;
    frame_t live;
    frame_t view;
    logic [3:0] digit;
    logic [6:0] digit_seg;
    logic       blank;
    logic       colon;

    // Upper seconds bits carry no display meaning; only the parity drives the colon.
    logic sec_high_unused;
    assign sec_high_unused = ^counter_sec[5:1];

    assign tick       = (pre == PRE_LAST);
    assign frame_wrap = tick && (idx == SLOT_HT);
    assign next_slot  = slot_t'(idx + 2'd1);

    // The first wrap after reset only starts the scan; blink frames are
    // counted from the second wrap on, so the first BLINK_FRAMES frames are lit.
    assign phase_flip = frame_wrap && running && (fcnt == FC_TERM);

    // Slot 0 is loaded on the same edge that updates bph, so it must see the new phase.
    assign bph_eff = phase_flip ? ~bph : bph;

    // Gather live inputs, tens zero-extended to BCD width.
    always_comb begin
        live             = '0;
        live.mu          = minutes_units;
        live.mt          = {1'b0, minutes_tens};
        live.hu          = hours_units;
        live.ht          = {1'b0, hours_tens};
        live.sec_lsb     = counter_sec[0];
        live.blink_mins  = blink_mins;
        live.blink_hours = blink_hours;
    end

    // Slot 0 is loaded on the snapshot edge itself, so it takes the live values.
    assign view = frame_wrap ? live : snap;

    // Select the digit for the slot about to be shown.
    always_comb begin
        digit = view.mu;
        case (next_slot)
            SLOT_MU: digit = view.mu;
            SLOT_MT: digit = view.mt;
            SLOT_HU: digit = view.hu;
            default: digit = view.ht;
        endcase
    end

    seg7_decode u_decode (
        .value (digit),
        .seg   (digit_seg)
    );

    // Decide whether the upcoming slot is blanked and whether the colon is lit.
    always_comb begin
        blank = 1'b0;
        if (!bph_eff) begin
            if ((next_slot == SLOT_MU || next_slot == SLOT_MT) && view.blink_mins)
                blank = 1'b1;
            if ((next_slot == SLOT_HU || next_slot == SLOT_HT) && view.blink_hours)
                blank = 1'b1;
        end
        if (SUPPRESS_LZ != 0 && next_slot == SLOT_HT && view.ht == 4'd0)
            blank = 1'b1;
        colon = (next_slot == SLOT_HU) && !view.sec_lsb && !blank;
    end

    // Refresh prescaler: one tick per digit slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pre <= '0;
        else if (tick)
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block ordering.
            pre <= '0;
        else
            pre <= pre + PRE_W'(1);
    end

    // Digit index, parked at the last slot so the first tick shows slot 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idx <= SLOT_HT;
        else if (tick)
            idx <= next_slot;
    end

    // Frame snapshot, taken once per frame on the wrap to slot 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            // NOTE: the snapshot is plain flops, so clearing it on reset is cheap
            // and keeps blink/colon decisions defined before the first frame.
            snap <= '0;
        else if (frame_wrap)
            snap <= live;
    end

    // Blink phase and completed-frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bph     <= 1'b1;
            fcnt    <= '0;
            running <= 1'b0;
        end else begin
            if (tick)
                running <= 1'b1;
            if (frame_wrap && running) begin
                if (fcnt == FC_TERM) begin
                    fcnt <= '0;
                    bph  <= ~bph;
                end else begin
                    fcnt <= fcnt + FC_W'(1);
                end
            end
        end
    end

    // Registered display outputs, updated only at slot boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode <= AN_OFF;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
        end else if (tick) begin
            anode <= blank ? AN_OFF : slot_anode(next_slot);
            seg   <= blank ? SEG_BLANK : digit_seg;
            dp    <= ~colon;
        end
    end

endmodule
